// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - iterative one-bit-per-cycle barrel shifter (pass/LSL/LSR/ASR)
// Define ITER_SHIFTER_ROR_EN to turn op 00 with nonzero amt into rotate-right.
module iter_shifter #(
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [(2**AW)-1:0]  in,
  input  logic [1:0]          shift,
  input  logic [AW-1:0]       amt,
  output logic                busy,
  output logic                done,
  output logic [(2**AW)-1:0]  sout
);

  localparam int W = 2**AW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    work;
  logic [W-1:0]    stepped;
  logic [W-1:0]    sout_r;
  logic [AW-1:0]   count;
  logic [1:0]      op;
  logic            accept;
  logic            zero_dist;
  logic            last_step;

  assign accept    = start && (state != SHIFT);
  assign last_step = (count == AW'(1));

`ifdef ITER_SHIFTER_ROR_EN
  assign zero_dist = (amt == '0);
`else
  // Pass with a nonzero distance is a no-op, so it completes immediately.
  assign zero_dist = (amt == '0) || (shift == 2'b00);
`endif

  always_comb begin
    stepped = work;
    case (op)
      2'b01:   stepped = {work[W-2:0], 1'b0};
      2'b10:   stepped = {1'b0, work[W-1:1]};
      2'b11:   stepped = {work[W-1], work[W-1:1]};
`ifdef ITER_SHIFTER_ROR_EN
      default: stepped = {work[0], work[W-1:1]};
`else
      default: stepped = work;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = zero_dist ? DONE : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        state_nxt = last_step ? DONE : SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // sout is written only on entry to DONE so partial results stay hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      work   <= '0;
      count  <= '0;
      op     <= 2'b00;
      sout_r <= '0;
    end else if (accept) begin
      work  <= in;
      count <= amt;
      op    <= shift;
      if (zero_dist) begin
        sout_r <= in;
      end
    end else if (state == SHIFT) begin
      work  <= stepped;
      count <= count - AW'(1);
      if (last_step) begin
        sout_r <= stepped;
      end
    end
  end

  assign sout = sout_r;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter with directed vectors
module tb_iter_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in_d;
  logic [1:0]  shift;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b0;
  logic [15:0] held = 16'h0;

  logic [15:0] exp_q[$];
  int          cyc_q[$];

  iter_shifter #(.AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_d),
    .shift (shift),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Monitor: every done pulse must match the oldest expectation, in value and cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    int          ec;
    if (rst_q) begin
      held = 16'h0;
    end else if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done sout=%h cyc=%0d", sout, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if (sout !== e) begin
          errors++;
          $display("FAIL sout got=%h exp=%h", sout, e);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc, ec);
        end
        held = e;
      end
    end else begin
      checks++;
      if (sout !== held) begin
        errors++;
        $display("FAIL sout_hold got=%h exp=%h", sout, held);
      end
    end
  end

  task automatic issue(input logic [15:0] d, input logic [1:0] op, input logic [3:0] a,
                       input logic [15:0] e, input int lat, input bit expect_done);
    in_d  = d;
    shift = op;
    amt   = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + lat);
    end
  endtask

  task automatic wait_done(input int exp_busy);
    int nb = 0;
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout got=0 exp=1");
    end
    if (exp_busy >= 0) begin
      checks++;
      if (nb != exp_busy) begin
        errors++;
        $display("FAIL busy_cycles got=%0d exp=%0d", nb, exp_busy);
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_d  = 16'h0;
    shift = 2'b00;
    amt   = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {15'h0, busy}, 16'h0);
    chk("reset_done", {15'h0, done}, 16'h0);
    chk("reset_sout", sout, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(16'h00FF, 2'b01, 4'd4, 16'h0FF0, 4, 1);
    wait_done(4);
    issue(16'h8001, 2'b11, 4'd3, 16'hF000, 3, 1);
    wait_done(3);
    issue(16'h8000, 2'b10, 4'd15, 16'h0001, 15, 1);
    wait_done(15);
    issue(16'h1234, 2'b01, 4'd0, 16'h1234, 0, 1);
    wait_done(0);

    // A start while busy must not disturb the running LSL.
    issue(16'h00FF, 2'b01, 4'd4, 16'h0FF0, 4, 1);
    @(posedge clk);
    #1;
    in_d  = 16'hFFFF;
    shift = 2'b01;
    amt   = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(-1);

    // Back-to-back: second start accepted in the DONE cycle.
    issue(16'hFFFF, 2'b01, 4'd15, 16'h8000, 15, 1);
    wait_done(15);
    issue(16'h7FF0, 2'b11, 4'd4, 16'h07FF, 4, 1);
    wait_done(4);

`ifdef ITER_SHIFTER_ROR_EN
    issue(16'h0001, 2'b00, 4'd1, 16'h8000, 1, 1);
    wait_done(1);
    issue(16'h1234, 2'b00, 4'd5, 16'hA091, 5, 1);
    wait_done(5);
`else
    issue(16'h0001, 2'b00, 4'd1, 16'h0001, 0, 1);
    wait_done(0);
    issue(16'h1234, 2'b00, 4'd5, 16'h1234, 0, 1);
    wait_done(0);
`endif

    // Reset at E+2 aborts the shift; the monitor flags any stray done.
    issue(16'h00FF, 2'b01, 4'd4, 16'h0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {15'h0, busy}, 16'h0);
    chk("abort_done", {15'h0, done}, 16'h0);
    chk("abort_sout", sout, 16'h0);
    repeat (8) @(negedge clk);

    issue(16'h0F0F, 2'b10, 4'd8, 16'h000F, 8, 1);
    wait_done(8);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
